siso_elastic: RTL

- Parametrised elastic successor to the team's fixed shift-register SISO.
- DEPTH-stage pipeline of DATA_WIDTH-bit registers; each stage carries its own valid bit.
- Data advances only into empty or draining stages, so bubbles collapse and the block buffers up to DEPTH items under output backpressure.
- Used as a configurable-latency delay line and skid buffer on valid/ready streams; adds synchronous flush and occupancy count.

---
 rtl/siso_elastic.sv | 87 ++++++++
 1 files changed

// File: rtl/siso_elastic.sv
// Elastic DEPTH-stage delay line / skid buffer on a valid/ready stream.
// Items advance into empty or draining stages, so bubbles collapse under backpressure.
module siso_elastic #(
    parameter int unsigned  DATA_WIDTH = 8,
    parameter int unsigned  DEPTH      = 5,
    localparam int unsigned CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  arst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ready,
    input  logic                  flush_i,
    output logic [CNT_WIDTH-1:0]  count_o
);

    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [DEPTH-1:0]      r_v;
    logic [CNT_WIDTH-1:0]  r_count;

    logic [DEPTH-1:0]      w_mv;
    logic                  w_in_fire;
    logic                  w_out_fire;
    logic [CNT_WIDTH-1:0]  w_count_nxt;

    // A stage may move if it, or any stage downstream of it, is empty, or the output drains.
    always_comb begin : move_enables
        logic l_acc;
        w_mv  = '0;
        l_acc = data_out_ready;
        for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
            l_acc   = l_acc | ~r_v[k];
            w_mv[k] = l_acc;
        end
    end

    assign data_in_ready = w_mv[0] & ~flush_i;
    assign w_in_fire     = data_in_valid & data_in_ready;
    assign w_out_fire    = r_v[DEPTH-1] & data_out_ready;

    always_comb begin
        w_count_nxt = r_count;
        if (flush_i) begin
            w_count_nxt = '0;
        end else begin
            w_count_nxt = r_count + CNT_WIDTH'(w_in_fire) - CNT_WIDTH'(w_out_fire);
        end
    end

    always_ff @(posedge clk_i or negedge arst_n) begin
        if (!arst_n) begin
            r_v     <= '0;
            r_count <= '0;
            for (int k = 0; k < int'(DEPTH); k++) begin
                r_data[k] <= '0;
            end
        end else begin
            r_count <= w_count_nxt;
            if (w_mv[0]) begin
                r_v[0] <= data_in_valid & ~flush_i;
                if (data_in_valid) begin
                    r_data[0] <= data_in;
                end
            end
            // Data registers only load real items so bubbles leave payloads untouched.
            for (int k = 1; k < int'(DEPTH); k++) begin
                if (w_mv[k]) begin
                    r_v[k] <= r_v[k-1];
                    if (r_v[k-1]) begin
                        r_data[k] <= r_data[k-1];
                    end
                end
            end
            if (flush_i) begin
                r_v <= '0;
            end
        end
    end

    assign data_out       = r_data[DEPTH-1];
    assign data_out_valid = r_v[DEPTH-1];
    assign count_o        = r_count;

endmodule
